// File: rtl/tiny_exec_sequencer.sv
// tiny_exec_sequencer: multi-cycle fetch/execute sequencer for the 8-bit tinyProcessor.
// Owns ACC, the carry/compare flag and a 16x8 register file. ADD/SUB/loads/stores are
// executed locally. AND/XOR/CMP are handed to the external logical stage, and its result
// is committed at the end of EXEC.
module tiny_exec_sequencer #(
   parameter int unsigned RF_DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] instr_data,
   input  logic       instr_valid,
   output logic       instr_ready,
   output logic [7:0] lg_acc,
   output logic [7:0] lg_reg,
   output logic [1:0] lg_op,
   input  logic [7:0] lg_result,
   input  logic       lg_cmp,
   output logic [7:0] acc,
   output logic       c_flag,
   output logic       retire,
   output logic       halted
);

   typedef enum logic [1:0] {StFetch, StExec, StImm, StHalt} state_e;

   localparam logic [3:0] OpNop = 4'h0;
   localparam logic [3:0] OpAdd = 4'h1;
   localparam logic [3:0] OpSub = 4'h2;
   localparam logic [3:0] OpAnd = 4'h3;
   localparam logic [3:0] OpXor = 4'h4;
   localparam logic [3:0] OpCmp = 4'h5;
   localparam logic [3:0] OpSta = 4'h6;
   localparam logic [3:0] OpLda = 4'h7;
   localparam logic [3:0] OpLdi = 4'h8;
   localparam logic [3:0] OpHlt = 4'hF;

   localparam logic [1:0] LgAnd  = 2'b00;
   localparam logic [1:0] LgXor  = 2'b01;
   localparam logic [1:0] LgCmp  = 2'b10;
   localparam logic [1:0] LgIdle = 2'b11;

   state_e     state_q, state_d;
   logic [7:0] ir_q, ir_d;
   logic [7:0] acc_q, acc_d;
   logic       c_q, c_d;
   logic       retire_q, retire_d;
   logic [7:0] rf_q [RF_DEPTH];
   logic       rf_we;

   logic [3:0] opcode;
   logic [3:0] rf_idx;
   logic [7:0] rn;
   logic [8:0] sum;
   logic       handshake;

   assign opcode    = ir_q[7:4];
   assign rf_idx    = ir_q[3:0];
   assign rn        = rf_q[rf_idx];
   assign sum       = {1'b0, acc_q} + {1'b0, rn};
   assign handshake = instr_valid && instr_ready;

   // Ready is a pure function of state so it is high straight out of reset.
   always_comb begin
      instr_ready = (state_q == StFetch) || (state_q == StImm);
      halted      = (state_q == StHalt);
      acc         = acc_q;
      c_flag      = c_q;
      retire      = retire_q;
      lg_acc      = acc_q;
      lg_reg      = rn;
   end

   // Logical opcode is only asserted while the matching instruction sits in EXEC.
   always_comb begin
      lg_op = LgIdle;
      if (state_q == StExec) begin
         unique case (opcode)
            OpAnd:   lg_op = LgAnd;
            OpXor:   lg_op = LgXor;
            OpCmp:   lg_op = LgCmp;
            default: lg_op = LgIdle;
         endcase
      end
   end

   // Next-state and commit logic for the fetch/execute FSM.
   always_comb begin
      state_d  = state_q;
      ir_d     = ir_q;
      acc_d    = acc_q;
      c_d      = c_q;
      retire_d = 1'b0;
      rf_we    = 1'b0;
      unique case (state_q)
         StFetch: begin
            if (handshake) begin
               ir_d    = instr_data;
               state_d = StExec;
            end
         end
         StExec: begin
            state_d  = StFetch;
            retire_d = 1'b1;
            unique case (opcode)
               OpAdd: begin
                  acc_d = sum[7:0];
                  c_d   = sum[8];
               end
               OpSub: begin
                  acc_d = acc_q - rn;
                  c_d   = (acc_q < rn);
               end
               OpAnd, OpXor: acc_d = lg_result;
               OpCmp:        c_d   = lg_cmp;
               OpSta:        rf_we = 1'b1;
               OpLda:        acc_d = rn;
               OpLdi: begin
                  // LDI retires after its immediate byte, not here.
                  state_d  = StImm;
                  retire_d = 1'b0;
               end
               OpHlt:   state_d = StHalt;
               default: ; // NOP and unused opcodes 0x9-0xE
            endcase
         end
         StImm: begin
            if (handshake) begin
               acc_d    = instr_data;
               retire_d = 1'b1;
               state_d  = StFetch;
            end
         end
         StHalt: state_d = StHalt;
         default: state_d = StFetch;
      endcase
   end

   // Architectural state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StFetch;
         ir_q     <= 8'h00;
         acc_q    <= 8'h00;
         c_q      <= 1'b0;
         retire_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ir_q     <= ir_d;
         acc_q    <= acc_d;
         c_q      <= c_d;
         retire_q <= retire_d;
      end
   end

   // Register file; STA writes ACC into rf[IR[3:0]] at the EXEC commit edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < RF_DEPTH; i++) begin
            rf_q[i] <= 8'h00;
         end
      end else if (rf_we) begin
         rf_q[rf_idx] <= acc_q;
      end
   end

endmodule

// File: tb/tb_tiny_exec_sequencer.sv
// Directed bench for tiny_exec_sequencer with a behavioural logical stage.
module tb_tiny_exec_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] instr_data;
   logic       instr_valid;
   logic       instr_ready;
   logic [7:0] lg_acc, lg_reg, lg_result;
   logic [1:0] lg_op;
   logic       lg_cmp;
   logic [7:0] acc;
   logic       c_flag, retire, halted;

   int n_vec = 0;
   int n_err = 0;
   int retire_cnt = 0;
   int r0;

   tiny_exec_sequencer #(.RF_DEPTH(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .instr_data (instr_data),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .lg_acc     (lg_acc),
      .lg_reg     (lg_reg),
      .lg_op      (lg_op),
      .lg_result  (lg_result),
      .lg_cmp     (lg_cmp),
      .acc        (acc),
      .c_flag     (c_flag),
      .retire     (retire),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   // Logical stage model.
   assign lg_result = (lg_op == 2'b00) ? (lg_acc & lg_reg) :
                      (lg_op == 2'b01) ? (lg_acc ^ lg_reg) : 8'h00;
   assign lg_cmp    = (lg_acc < lg_reg);

   always @(negedge clk) if (retire === 1'b1) retire_cnt++;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Starts and ends at a negedge; returns at the negedge after the handshake edge.
   task automatic send(input logic [7:0] b);
      int n = 0;
      instr_valid = 1'b1;
      instr_data  = b;
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n == 20) check("send_timeout", 16'd0, 16'd1);
      @(negedge clk);
      instr_valid = 1'b0;
   endtask

   task automatic instr1(input logic [7:0] b);
      send(b);
      @(negedge clk);
   endtask

   task automatic ldi(input logic [7:0] v);
      send(8'h80);
      @(negedge clk);
      send(v);
   endtask

   initial begin
      rst = 1'b1;
      instr_valid = 1'b0;
      instr_data = 8'h00;
      @(negedge clk);
      check("rst_ready", {15'd0, instr_ready}, 16'd1);
      check("rst_acc", {8'd0, acc}, 16'h0000);
      check("rst_c", {15'd0, c_flag}, 16'd0);
      check("rst_retire", {15'd0, retire}, 16'd0);
      check("rst_halted", {15'd0, halted}, 16'd0);
      check("rst_lgop", {14'd0, lg_op}, 16'd3);
      rst = 1'b0;

      // Reset mid-EXEC, then with a retire pulse in flight.
      ldi(8'h55);
      check("ldi55_acc", {8'd0, acc}, 16'h0055);
      check("ldi55_retire", {15'd0, retire}, 16'd1);
      rst = 1'b1;
      #1;
      check("rst_retire_kill", {15'd0, retire}, 16'd0);
      check("rst_acc2", {8'd0, acc}, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      ldi(8'h55);
      send(8'h07);
      check("exec_ready", {15'd0, instr_ready}, 16'd0);
      rst = 1'b1;
      #1;
      check("rst_exec_ready", {15'd0, instr_ready}, 16'd1);
      check("rst_exec_acc", {8'd0, acc}, 16'h0000);
      check("rst_exec_lgop", {14'd0, lg_op}, 16'd3);
      @(negedge clk);
      rst = 1'b0;
      #1 r0 = retire_cnt;
      send(8'h80);
      @(negedge clk);
      check("ldi_imm_retire", {15'd0, retire}, 16'd0);
      send(8'h3C);
      check("ldi3c_acc", {8'd0, acc}, 16'h003C);
      #1 check("ldi3c_retires", 16'(retire_cnt - r0), 16'd1);

      // Store and ADD wrap-around.
      ldi(8'hFF);
      instr1(8'h62);
      ldi(8'h01);
      instr1(8'h12);
      check("add_acc", {8'd0, acc}, 16'h0000);
      check("add_c", {15'd0, c_flag}, 16'd1);
      check("rf2", {8'd0, lg_reg}, 16'h00FF);

      // SUB borrow and no-borrow.
      ldi(8'h01);
      instr1(8'h63);
      ldi(8'h00);
      instr1(8'h23);
      check("sub_acc", {8'd0, acc}, 16'h00FF);
      check("sub_c", {15'd0, c_flag}, 16'd1);
      ldi(8'h05);
      instr1(8'h23);
      check("sub2_acc", {8'd0, acc}, 16'h0004);
      check("sub2_c", {15'd0, c_flag}, 16'd0);

      // Logical handoff: C is set beforehand to prove AND/XOR leave it alone.
      ldi(8'h3C);
      instr1(8'h61);
      ldi(8'h00);
      instr1(8'h21);
      check("sub3_acc", {8'd0, acc}, 16'h00C4);
      ldi(8'hF0);
      send(8'h31);
      check("and_lgop_exec", {14'd0, lg_op}, 16'd0);
      @(negedge clk);
      check("and_lgop_idle", {14'd0, lg_op}, 16'd3);
      check("and_acc", {8'd0, acc}, 16'h0030);
      check("and_c", {15'd0, c_flag}, 16'd1);
      ldi(8'hF0);
      send(8'h41);
      check("xor_lgop_exec", {14'd0, lg_op}, 16'd1);
      @(negedge clk);
      check("xor_acc", {8'd0, acc}, 16'h00CC);
      check("xor_c", {15'd0, c_flag}, 16'd1);
      ldi(8'h20);
      instr1(8'h61);
      ldi(8'h10);
      instr1(8'h10);
      check("add0_c", {15'd0, c_flag}, 16'd0);
      send(8'h51);
      check("cmp_lgop_exec", {14'd0, lg_op}, 16'd2);
      @(negedge clk);
      check("cmp_c", {15'd0, c_flag}, 16'd1);
      check("cmp_acc", {8'd0, acc}, 16'h0010);
      ldi(8'h30);
      instr1(8'h51);
      check("cmp2_c", {15'd0, c_flag}, 16'd0);

      // Read-after-write: STA R5 then ADD R5.
      ldi(8'h77);
      instr1(8'h65);
      instr1(8'h15);
      check("raw_acc", {8'd0, acc}, 16'h00EE);

      // Stall in FETCH; garbage during EXEC must be ignored.
      #1 r0 = retire_cnt;
      for (int i = 0; i < 5; i++) begin
         instr_data = 8'(8'h70 + i);
         @(negedge clk);
      end
      check("stall_f_ready", {15'd0, instr_ready}, 16'd1);
      check("stall_f_acc", {8'd0, acc}, 16'h00EE);
      #1 check("stall_f_retire", 16'(retire_cnt - r0), 16'd0);
      send(8'h80);
      instr_valid = 1'b1;
      instr_data  = 8'h11;
      @(negedge clk);
      instr_valid = 1'b0;
      #1 r0 = retire_cnt;
      for (int i = 0; i < 5; i++) begin
         instr_data = 8'(8'hA0 + i);
         @(negedge clk);
      end
      check("stall_i_ready", {15'd0, instr_ready}, 16'd1);
      check("stall_i_acc", {8'd0, acc}, 16'h00EE);
      #1 check("stall_i_retire", 16'(retire_cnt - r0), 16'd0);
      send(8'h9A);
      check("imm_acc", {8'd0, acc}, 16'h009A);

      // Halt: one retire, bytes ignored, only reset recovers.
      #1 r0 = retire_cnt;
      instr1(8'hF0);
      check("hlt_halted", {15'd0, halted}, 16'd1);
      instr_valid = 1'b1;
      instr_data  = 8'h70;
      for (int i = 0; i < 5; i++) @(negedge clk);
      check("hlt_ready", {15'd0, instr_ready}, 16'd0);
      check("hlt_still", {15'd0, halted}, 16'd1);
      check("hlt_acc", {8'd0, acc}, 16'h009A);
      #1 check("hlt_retires", 16'(retire_cnt - r0), 16'd1);
      instr_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("hlt_rst_halted", {15'd0, halted}, 16'd0);
      check("hlt_rst_ready", {15'd0, instr_ready}, 16'd1);
      @(negedge clk);
      rst = 1'b0;
      ldi(8'h11);
      check("recover_acc", {8'd0, acc}, 16'h0011);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tiny_exec_sequencer.md
# tiny_exec_sequencer

Multi-cycle fetch/execute sequencer for the 8-bit tinyProcessor. It sits directly upstream and downstream of the logical-operation stage. It accepts instruction bytes over a valid/ready handshake, holds the accumulator, carry/compare flag and a 16×8 register file, and performs ADD/SUB/loads/stores itself. For AND/XOR/CMP it drives the logical stage's operand and opcode inputs and commits that stage's result and compare flag.

## Interface
- `RF_DEPTH`, default 16: register-file entries; the index is `instr_data[3:0]`, fixed at 16.
- `clk` — input, 1: single clock; all state updates on the rising edge.
- `rst` — input, 1: asynchronous, active-high reset.
- `instr_data` — input, 8: instruction or immediate byte.
- `instr_valid` — input, 1: `instr_data` is valid.
- `instr_ready` — output, 1: the sequencer accepts a byte this cycle.
- `lg_acc` — output, 8: accumulator operand to the logical stage.
- `lg_reg` — output, 8: register operand to the logical stage.
- `lg_op` — output, 2: logical opcode. 00 is AND, 01 is XOR, 10 is CMP, 11 is idle.
- `lg_result` — input, 8: logical stage result.
- `lg_cmp` — input, 1: logical stage compare flag, meaning acc < reg.
- `acc` — output, 8: accumulator.
- `c_flag` — output, 1: carry/borrow/compare flag.
- `retire` — output, 1: one-cycle pulse per committed instruction.
- `halted` — output, 1: high in the HALT state.

## Operation
- **Encoding:** `opcode = instr_data[7:4]`, `n = instr_data[3:0]`, `Rn = rf[n]`.
  - 0x0 NOP.
  - 0x1 ADD: `{C, ACC} = ACC + Rn`, 9-bit sum.
  - 0x2 SUB: `ACC = ACC - Rn` mod 256; `C = 1` iff `ACC < Rn`, unsigned borrow.
  - 0x3 AND: `lg_op = 00`; `ACC = lg_result`; C unchanged.
  - 0x4 XOR: `lg_op = 01`; `ACC = lg_result`; C unchanged.
  - 0x5 CMP: `lg_op = 10`; `C = lg_cmp`; ACC unchanged.
  - 0x6 STA: `rf[n] = ACC`.
  - 0x7 LDA: `ACC = Rn`.
  - 0x8 LDI: two-byte instruction. The next accepted byte is loaded into ACC; `n` is ignored.
  - 0xF HLT.
  - 0x9–0xE execute as NOP.
- **States:**
  - FETCH: `instr_ready = 1`. A handshake (`instr_valid && instr_ready` at an edge) latches the byte into IR and goes to EXEC.
  - EXEC: `instr_ready = 0`. Operands are combinational from ACC, `rf[IR[3:0]]` and IR. Results commit at the edge ending EXEC.
    - LDI goes to IMM.
    - HLT goes to HALT.
    - All other opcodes go to FETCH.
  - IMM: `instr_ready = 1`. A handshake loads ACC with `instr_data` and goes to FETCH.
  - HALT: `instr_ready = 0`. Stays in HALT until `rst`.
- **Logical stage drive:**
  - `lg_acc = ACC` and `lg_reg = rf[IR[3:0]]` at all times.
  - `lg_op` takes the mapped value only in EXEC with opcode 0x3/0x4/0x5; otherwise it is 11.
  - `lg_result` and `lg_cmp` are sampled only at the EXEC commit edge.
- **Retire:** `retire` is registered, high for exactly one cycle after the commit edge of every instruction.
  - NOP and HLT retire from EXEC.
  - LDI retires once, after the IMM handshake, not after its EXEC.
- **Reset values:**
  - State: FETCH.
  - ACC, C, IR and all `rf` entries: 0.
  - `retire`: 0. `halted`: 0. `lg_op`: 11.
  - `instr_ready`: 1 immediately, combinational from state.

## Timing
- Single-byte instruction: handshake edge, one EXEC cycle, commit. Minimum 2 cycles per instruction; ACC/C/rf are visible the cycle after commit.
- LDI: a minimum of 3 cycles. IMM waits indefinitely for `instr_valid`.
- Stalls: `instr_valid = 0` in FETCH or IMM holds the state; there are no side effects.
- Handshake rules:
  - `instr_data` is ignored whenever `instr_ready = 0`.
  - The source must hold the byte until a handshake occurs.
- Back-to-back: a valid byte is accepted every other cycle, e.g. LDA then STA.
- Read-after-write: a `rf` write and a read of the same index in the next instruction returns the new value, because commit precedes the next EXEC.
- Reset mid-operation: asynchronous return to reset values in any state, including mid-LDI and HALT. A `retire` pulse in flight is cleared.
- Wrap-around: ADD 0xFF+0x01 gives ACC=0x00, C=1. SUB 0x00-0x01 gives ACC=0xFF, C=1.

## Test plan
- **Reset and load:**
  - Stimulus: assert `rst` mid-EXEC; release; send LDI, then 0x3C.
  - Response: all outputs at reset values while `rst` is high; ACC=0x3C; a single `retire` pulse.
- **Store and ADD:**
  - Stimulus: LDI 0xFF, STA R2, LDI 0x01, ADD R2.
  - Response: `rf[2]` = 0xFF; ACC=0x00; C=1.
- **SUB borrow:**
  - Stimulus: ACC=0x00, `rf[3]` = 0x01, SUB R3.
  - Response: ACC=0xFF; C=1.
- **Logical handoff** (bench models the logical stage):
  - AND with ACC=0xF0, R1=0x3C: `lg_op` = 00 only during EXEC; ACC=0x30; C unchanged.
  - XOR with the same operands: ACC=0xCC.
  - CMP with ACC=0x10, R1=0x20: C=1, ACC=0x10.
- **Handshake stall:**
  - Stimulus: `instr_valid` low for 5 cycles in FETCH and in IMM; `instr_data` toggled while `instr_ready` = 0.
  - Response: no state change; no `retire`; the toggled bytes are never latched.
- **Halt:**
  - Stimulus: HLT, then valid bytes presented.
  - Response: `halted` = 1; `instr_ready` = 0 forever; one `retire`; only `rst` recovers.
